// File: rtl/prng_uart_tx.sv
// -----------------------------------------------------------------------------
// prng_uart_tx
//
// Streams 64-bit words from an external pseudo-random generator over an 8N1
// UART line. Each word is sent as eight bytes, most-significant byte first,
// with each byte's bits sent LSB first. One io_next pulse is issued per word,
// on the same edge that captures the generator value.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-low reset
//   io_start     : stream request, sampled only while idle
//   io_count     : number of 64-bit words to send, sampled with io_start
//   io_prngHigh  : upper 32 bits of the current generator value
//   io_prngLow   : lower 32 bits of the current generator value
//   io_next      : one-cycle pulse that advances the generator
//   io_txd       : registered UART serial line, idle high
//   io_busy      : high while a stream is in progress
// -----------------------------------------------------------------------------
module prng_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_start,
  input  logic [7:0]  io_count,
  input  logic [31:0] io_prngHigh,
  input  logic [31:0] io_prngLow,
  output logic        io_next,
  output logic        io_txd,
  output logic        io_busy
);

  // Bit-period counter counts down from here to 0; 0 marks the bit boundary.
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      r_state;
  logic [7:0]  r_remaining;
  logic [63:0] r_shift;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_idx;
  logic [2:0]  r_byte_idx;
  logic        r_txd;

  state_t      w_state_nx;
  logic [7:0]  w_remaining_nx;
  logic [63:0] w_shift_nx;
  logic [15:0] w_baud_nx;
  logic [2:0]  w_bit_idx_nx;
  logic [2:0]  w_byte_idx_nx;
  logic        w_txd_nx;
  logic [7:0]  w_tx_byte;
  logic        w_bit_end;

  assign w_bit_end = (r_baud == 16'd0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    w_state_nx     = r_state;
    w_remaining_nx = r_remaining;
    w_shift_nx     = r_shift;
    w_baud_nx      = r_baud;
    w_bit_idx_nx   = r_bit_idx;
    w_byte_idx_nx  = r_byte_idx;
    w_txd_nx       = 1'b1;
    w_tx_byte      = 8'h00;

    unique case (r_state)
      S_IDLE: begin
        if (io_start && (io_count != 8'd0)) begin
          w_remaining_nx = io_count;
          w_state_nx     = S_LOAD;
        end
      end

      S_LOAD: begin
        w_shift_nx     = {io_prngHigh, io_prngLow};
        w_remaining_nx = r_remaining - 8'd1;
        w_baud_nx      = BAUD_LAST;
        w_byte_idx_nx  = 3'd0;
        w_state_nx     = S_START;
      end

      S_START: begin
        if (w_bit_end) begin
          w_baud_nx    = BAUD_LAST;
          w_bit_idx_nx = 3'd0;
          w_state_nx   = S_DATA;
        end else begin
          w_baud_nx = r_baud - 16'd1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nx = BAUD_LAST;
          if (r_bit_idx == 3'd7) begin
            w_state_nx = S_STOP;
          end else begin
            w_bit_idx_nx = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nx = r_baud - 16'd1;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nx     = BAUD_LAST;
          // The byte on the wire is always the top byte; shift the next one up.
          w_shift_nx    = {r_shift[55:0], 8'h00};
          w_byte_idx_nx = r_byte_idx + 3'd1;
          if (r_byte_idx == 3'd7) begin
            w_state_nx = (r_remaining != 8'd0) ? S_LOAD : S_IDLE;
          end else begin
            w_state_nx = S_START;
          end
        end else begin
          w_baud_nx = r_baud - 16'd1;
        end
      end

      default: w_state_nx = S_IDLE;
    endcase

    // The line level is derived from the next state so io_txd can come
    // straight from a flop and still line up with the state it belongs to.
    w_tx_byte = w_shift_nx[63:56];
    unique case (w_state_nx)
      S_START: w_txd_nx = 1'b0;
      S_DATA:  w_txd_nx = w_tx_byte[w_bit_idx_nx];
      default: w_txd_nx = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= 8'd0;
      r_shift     <= 64'd0;
      r_baud      <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_byte_idx  <= 3'd0;
      r_txd       <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_remaining <= w_remaining_nx;
      r_shift     <= w_shift_nx;
      r_baud      <= w_baud_nx;
      r_bit_idx   <= w_bit_idx_nx;
      r_byte_idx  <= w_byte_idx_nx;
      r_txd       <= w_txd_nx;
    end
  end

  assign io_txd  = r_txd;
  assign io_busy = (r_state != S_IDLE);
  assign io_next = (r_state == S_LOAD);

endmodule

// File: tb/tb_prng_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_prng_uart_tx
//
// Self-checking bench for prng_uart_tx with CLKS_PER_BIT = 4. A timeline model
// predicts busy/next/txd for every cycle from the stream's elapsed cycle count;
// a UART receiver decodes the line for literal byte/word checks.
// -----------------------------------------------------------------------------
module tb_prng_uart_tx;

  localparam int C = 4;             // clocks per bit
  localparam int P = 1 + 80 * C;    // cycles per word (321)

  logic        clk;
  logic        reset;
  logic        io_start;
  logic [7:0]  io_count;
  logic [31:0] io_prngHigh;
  logic [31:0] io_prngLow;
  logic        io_next;
  logic        io_txd;
  logic        io_busy;

  prng_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .io_start   (io_start),
    .io_count   (io_count),
    .io_prngHigh(io_prngHigh),
    .io_prngLow (io_prngLow),
    .io_next    (io_next),
    .io_txd     (io_txd),
    .io_busy    (io_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- generator environment ----------------
  logic [63:0] gen_val;
  logic        gen_set;
  logic [63:0] gen_set_val;
  logic        gen_inc;

  always @(posedge clk) begin
    if (gen_set)      gen_val <= gen_set_val;
    else if (io_next) gen_val <= gen_inc ? gen_val + 64'd1 : {$urandom, $urandom};
  end

  assign io_prngHigh = gen_val[63:32];
  assign io_prngLow  = gen_val[31:0];

  // ---------------- timeline model ----------------
  logic        m_active;
  int          m_t;
  int          m_n;
  logic [63:0] m_word;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_n      <= 0;
      m_word   <= 64'd0;
    end else if (m_active) begin
      if ((m_t % P) == 0) m_word <= {io_prngHigh, io_prngLow};
      if (m_t + 1 == m_n * P) m_active <= 1'b0;
      m_t <= m_t + 1;
    end else if (io_start && io_count != 8'd0) begin
      m_active <= 1'b1;
      m_t      <= 0;
      m_n      <= int'(io_count);
    end
  end

  // Returns {busy, next, txd} for a stream elapsed-cycle t.
  function automatic logic [2:0] model_out(input logic active, input int t, input logic [63:0] word);
    int r, k, byt, bi;
    logic [7:0] b;
    if (!active) return 3'b001;
    r = t % P;
    if (r == 0) return 3'b111;
    k   = r - 1;
    byt = k / (10 * C);
    bi  = (k % (10 * C)) / C;
    b   = word[63 - 8 * byt -: 8];
    if (bi == 0) return 3'b100;
    if (bi == 9) return 3'b101;
    return {2'b10, b[bi - 1]};
  endfunction

  logic [2:0] exp_v;
  always @(negedge clk) begin
    if (reset) begin
      exp_v = model_out(m_active, m_t, m_word);
      check("busy", {63'd0, io_busy}, {63'd0, exp_v[2]});
      check("next", {63'd0, io_next}, {63'd0, exp_v[1]});
      check("txd",  {63'd0, io_txd},  {63'd0, exp_v[0]});
    end
  end

  // ---------------- activity counters ----------------
  int cyc = 0;
  int busy_cnt = 0;
  int next_cnt = 0;
  int low_cnt = 0;
  int next_times[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      if (io_busy) busy_cnt <= busy_cnt + 1;
      if (!io_txd) low_cnt <= low_cnt + 1;
      if (io_next) begin
        next_cnt <= next_cnt + 1;
        next_times.push_back(cyc);
      end
    end
  end

  // ---------------- UART receiver ----------------
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;

  initial begin
    forever begin
      @(negedge clk);
      if (reset && io_txd == 1'b0) begin
        repeat (2) @(negedge clk);
        check("rx_start", {63'd0, io_txd}, 64'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          rx_b[i] = io_txd;
        end
        repeat (C) @(negedge clk);
        check("rx_stop", {63'd0, io_txd}, 64'd1);
        rx_q.push_back(rx_b);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_stream(input logic [7:0] cnt);
    @(negedge clk);
    io_start = 1'b1;
    io_count = cnt;
    @(negedge clk);
    io_start = 1'b0;
  endtask

  task automatic set_gen(input logic [63:0] v, input logic inc);
    @(negedge clk);
    gen_set     = 1'b1;
    gen_set_val = v;
    gen_inc     = inc;
    @(negedge clk);
    gen_set = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (!io_busy) break;
    end
    check(name, {63'd0, io_busy}, 64'd0);
    repeat (5) @(negedge clk);
  endtask

  int b0, n0, l0;
  int cnt_r, hold_r;
  logic [63:0] w_exp, w_got;

  initial begin
    reset       = 1'b1;
    io_start    = 1'b0;
    io_count    = 8'd0;
    gen_set     = 1'b1;
    gen_set_val = {$urandom, $urandom};
    gen_inc     = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_txd",  {63'd0, io_txd},  64'd1);
    check("rst_busy", {63'd0, io_busy}, 64'd0);
    check("rst_next", {63'd0, io_next}, 64'd0);

    // Release reset with io_start already high: first edge must accept it.
    repeat (2) @(posedge clk);
    #2;
    io_start = 1'b1;
    io_count = 8'd1;
    gen_set  = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_accept", {63'd0, io_busy}, 64'd1);
    io_start = 1'b0;
    wait_idle("idle_after_first", 400);

    // Scenario: single known word.
    set_gen(64'h0123456789ABCDEF, 1'b0);
    b0 = busy_cnt; n0 = next_cnt;
    rx_q.delete();
    start_stream(8'd1);
    wait_idle("idle_s1", 400);
    check("s1_busy_cycles", 64'(busy_cnt - b0), 64'd321);
    check("s1_next_pulses", 64'(next_cnt - n0), 64'd1);
    check("s1_rx_count", 64'(rx_q.size()), 64'd8);
    w_exp = 64'h0123456789ABCDEF;
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      check("s1_rx_byte", {56'd0, rx_q[i]}, {56'd0, w_exp[63 - 8 * i -: 8]});
    check("s1_model_word", m_word, 64'h0123456789ABCDEF);

    // Scenario: three words from an incrementing generator.
    set_gen(64'd0, 1'b1);
    next_times.delete();
    rx_q.delete();
    start_stream(8'd3);
    wait_idle("idle_s2", 1100);
    check("s2_next_pulses", 64'(next_times.size()), 64'd3);
    if (next_times.size() == 3) begin
      check("s2_next_gap0", 64'(next_times[1] - next_times[0]), 64'd321);
      check("s2_next_gap1", 64'(next_times[2] - next_times[1]), 64'd321);
    end
    check("s2_rx_count", 64'(rx_q.size()), 64'd24);
    for (int w = 0; w < 3 && rx_q.size() == 24; w++) begin
      w_got = 64'd0;
      for (int j = 0; j < 8; j++) w_got = {w_got[55:0], rx_q[8 * w + j]};
      check("s2_word", w_got, 64'(w));
    end
    check("s2_model_word", m_word, 64'd2);

    // Scenario: io_count = 0 must do nothing.
    b0 = busy_cnt; n0 = next_cnt; l0 = low_cnt;
    @(negedge clk);
    io_start = 1'b1;
    io_count = 8'd0;
    repeat (100) @(negedge clk);
    io_start = 1'b0;
    repeat (2) @(negedge clk);
    check("s3_busy_cycles", 64'(busy_cnt - b0), 64'd0);
    check("s3_next_pulses", 64'(next_cnt - n0), 64'd0);
    check("s3_txd_low",     64'(low_cnt - l0),  64'd0);

    // Scenario: restart attempts and generator changes mid-stream are ignored.
    set_gen({$urandom, $urandom}, 1'b0);
    b0 = busy_cnt; n0 = next_cnt;
    rx_q.delete();
    start_stream(8'd5);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(100, 400)) @(negedge clk);
      io_start    = 1'b1;
      io_count    = 8'd7;
      gen_set     = 1'b1;
      gen_set_val = {$urandom, $urandom};
      @(negedge clk);
      io_start = 1'b0;
      gen_set  = 1'b0;
    end
    wait_idle("idle_s4", 2000);
    check("s4_next_pulses", 64'(next_cnt - n0), 64'd5);
    check("s4_busy_cycles", 64'(busy_cnt - b0), 64'd1605);
    check("s4_rx_count", 64'(rx_q.size()), 64'd40);

    // Scenario: reset in byte 3, data bit 2.
    start_stream(8'd2);
    repeat (134) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("s5_txd_at_once",  {63'd0, io_txd},  64'd1);
    check("s5_busy_at_once", {63'd0, io_busy}, 64'd0);
    check("s5_next_at_once", {63'd0, io_next}, 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    b0 = busy_cnt; n0 = next_cnt; l0 = low_cnt;
    repeat (50) @(negedge clk);
    rx_q.delete();
    repeat (100) @(negedge clk);
    check("s5_next_after",  64'(next_cnt - n0), 64'd0);
    check("s5_busy_after",  64'(busy_cnt - b0), 64'd0);
    check("s5_low_after",   64'(low_cnt - l0),  64'd0);
    check("s5_rx_after",    64'(rx_q.size()),   64'd0);

    // Scenario: io_start held high gives back-to-back streams, one idle cycle apart.
    next_times.delete();
    @(negedge clk);
    io_start = 1'b1;
    io_count = 8'd2;
    repeat (2 * P + 5) @(negedge clk);
    io_start = 1'b0;
    wait_idle("idle_s6", 1000);
    check("s6_next_pulses", 64'(next_times.size()), 64'd4);
    if (next_times.size() == 4) begin
      check("s6_gap_word",   64'(next_times[1] - next_times[0]), 64'd321);
      check("s6_gap_stream", 64'(next_times[2] - next_times[1]), 64'd322);
    end

    // Randomized streams, checked cycle by cycle against the model.
    for (int it = 0; it < 4; it++) begin
      cnt_r  = $urandom_range(1, 3);
      hold_r = $urandom_range(1, 3);
      n0 = next_cnt;
      repeat ($urandom_range(1, 20)) @(negedge clk);
      io_start = 1'b1;
      io_count = 8'(cnt_r);
      repeat (hold_r) @(negedge clk);
      io_start = 1'b0;
      io_count = 8'($urandom);
      wait_idle("idle_rand", 1100);
      check("rand_next_pulses", 64'(next_cnt - n0), 64'(cnt_r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
